// File: rtl/core_pkg.sv
// Shared types for the CPU-to-backend memory bridge: target select and FSM state.
package core_pkg;

  typedef enum logic [1:0] {
    TGT_ROM  = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_SRAM = 2'd2
  } target_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int ADDR_W = 25;

endpackage

// File: rtl/mem_lane_mux.sv
// Byte-lane steering between narrow CPU ports and the 32-bit backend bus.
// i_half=1 selects 16-bit (ROM) lanes, i_half=0 selects 8-bit (SRAM) lanes.
module mem_lane_mux (
  input  logic        i_half,
  input  logic [1:0]  i_lane,
  input  logic [7:0]  i_wbyte,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [15:0] o_rhalf,
  output logic [7:0]  o_rbyte
);

  always_comb begin
    o_be    = i_half ? (i_lane[1] ? 4'b1100 : 4'b0011) : (4'b0001 << i_lane);
    o_wdata = {4{i_wbyte}};
    o_rhalf = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_lane)
      2'd0:    o_rbyte = i_rdata[7:0];
      2'd1:    o_rbyte = i_rdata[15:8];
      2'd2:    o_rbyte = i_rdata[23:16];
      default: o_rbyte = i_rdata[31:24];
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Bridges three CPU memory ports (ROM/RAM/SRAM) onto one 32-bit request/ack backend.
// Backend handshake: MEM_REQ is a level held with stable ADDR/WE/BE/WDATA until the edge MEM_ACK=1 is sampled.
module mem_bridge
  import core_pkg::*;
#(
  parameter logic [24:0] ROM_BASE  = 25'h0000000,
  parameter logic [24:0] RAM_BASE  = 25'h0200000,
  parameter logic [24:0] SRAM_BASE = 25'h0400000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        CPU_BCYSTn,
  input  logic [19:0] ROM_A,
  input  logic        ROM_CEn,
  output logic [15:0] ROM_DO,
  output logic        ROM_READYn,
  input  logic [20:0] RAM_A,
  input  logic [31:0] RAM_DI,
  input  logic        RAM_CEn,
  input  logic        RAM_WEn,
  input  logic [3:0]  RAM_BEn,
  output logic [31:0] RAM_DO,
  output logic        RAM_READYn,
  input  logic [14:0] SRAM_A,
  input  logic [7:0]  SRAM_DI,
  input  logic        SRAM_CEn,
  input  logic        SRAM_WEn,
  output logic [7:0]  SRAM_DO,
  output logic        SRAM_READYn,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  output logic [24:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  output state_t      DBG_STATE
);

  state_t      r_state, w_next;
  target_t     r_tgt, w_req_tgt;
  logic [1:0]  r_lane, w_req_lane, w_mux_lane;
  logic        w_mux_half;
  logic        w_sel_rom, w_sel_ram, w_sel_sram, w_one_sel, w_start, w_ack;
  logic [24:0] w_req_addr, r_mem_addr;
  logic        r_mem_we;
  logic [3:0]  r_mem_be, w_lane_be;
  logic [31:0] r_mem_wdata, w_lane_wdata;
  logic [15:0] r_rom_do, w_lane_rhalf;
  logic [31:0] r_ram_do;
  logic [7:0]  r_sram_do, w_lane_rbyte;

  assign w_sel_rom  = ~ROM_CEn;
  assign w_sel_ram  = ~RAM_CEn;
  assign w_sel_sram = ~SRAM_CEn;
  // Odd count of selects but not all three means exactly one.
  assign w_one_sel  = (w_sel_rom ^ w_sel_ram ^ w_sel_sram) & ~(w_sel_rom & w_sel_ram & w_sel_sram);
  assign w_start    = (r_state == ST_IDLE) & CE & ~CPU_BCYSTn & w_one_sel;
  assign w_ack      = (r_state == ST_REQ) & MEM_ACK;

  always_comb begin
    w_req_tgt  = TGT_SRAM;
    w_req_lane = {SRAM_A[0], 1'b0};
    w_req_addr = SRAM_BASE + {9'd0, SRAM_A[14:1], 2'b00};
    if (w_sel_rom) begin
      w_req_tgt  = TGT_ROM;
      w_req_lane = ROM_A[1:0];
      w_req_addr = ROM_BASE + {5'd0, ROM_A[19:2], 2'b00};
    end else if (w_sel_ram) begin
      w_req_tgt  = TGT_RAM;
      w_req_lane = 2'b00;
      w_req_addr = RAM_BASE + {4'd0, RAM_A[20:2], 2'b00};
    end
  end

  // One lane mux serves both directions: request side while idle, response side afterwards.
  assign w_mux_lane = (r_state == ST_IDLE) ? w_req_lane : r_lane;
  assign w_mux_half = (r_state == ST_IDLE) ? w_sel_rom : (r_tgt == TGT_ROM);

  mem_lane_mux u_lane_mux (
    .i_half  (w_mux_half),
    .i_lane  (w_mux_lane),
    .i_wbyte (SRAM_DI),
    .i_rdata (MEM_RDATA),
    .o_be    (w_lane_be),
    .o_wdata (w_lane_wdata),
    .o_rhalf (w_lane_rhalf),
    .o_rbyte (w_lane_rbyte)
  );

  always_ff @(posedge CLK) begin
    if (RES) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_REQ;
      ST_REQ:   if (MEM_ACK) w_next = ST_READY;
      ST_READY: if (CE)      w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    MEM_REQ     = (r_state == ST_REQ);
    ROM_READYn  = ~((r_state == ST_READY) & (r_tgt == TGT_ROM));
    RAM_READYn  = ~((r_state == ST_READY) & (r_tgt == TGT_RAM));
    SRAM_READYn = ~((r_state == ST_READY) & (r_tgt == TGT_SRAM));
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_tgt       <= TGT_ROM;
      r_lane      <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rom_do    <= '0;
      r_ram_do    <= '0;
      r_sram_do   <= '0;
    end else if (w_start) begin
      r_tgt      <= w_req_tgt;
      r_lane     <= w_req_lane;
      r_mem_addr <= w_req_addr;
      case (w_req_tgt)
        TGT_ROM: begin
          r_mem_we    <= 1'b0;
          r_mem_be    <= w_lane_be;
          r_mem_wdata <= '0;
        end
        TGT_RAM: begin
          r_mem_we    <= ~RAM_WEn;
          r_mem_be    <= ~RAM_BEn;
          r_mem_wdata <= RAM_DI;
        end
        default: begin
          r_mem_we    <= ~SRAM_WEn;
          r_mem_be    <= w_lane_be;
          r_mem_wdata <= w_lane_wdata;
        end
      endcase
    end else if (w_ack && !r_mem_we) begin
      case (r_tgt)
        TGT_ROM: r_rom_do  <= w_lane_rhalf;
        TGT_RAM: r_ram_do  <= MEM_RDATA;
        default: r_sram_do <= w_lane_rbyte;
      endcase
    end
  end

  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WE    = r_mem_we;
  assign MEM_BE    = r_mem_be;
  assign MEM_WDATA = r_mem_wdata;
  assign ROM_DO    = r_rom_do;
  assign RAM_DO    = r_ram_do;
  assign SRAM_DO   = r_sram_do;
  assign DBG_STATE = r_state;

endmodule
